// File: rtl/queue_stream_adapter_pkg.sv
// queue_stream_adapter_pkg
// Shared constants and types for the queue-to-stream adapter. The default data
// width and read latency are the same values the upstream multibuffer queue is
// built with, so both sides agree without repeating magic numbers.
// No ports (package).

package queue_stream_adapter_pkg;

    localparam int unsigned QSA_DATA_WIDTH   = 64;
    localparam int unsigned QSA_READ_LATENCY = 4;
    localparam int unsigned QSA_SKID_DEPTH   = 8;

    // Encoding is {push, pop} so the operation can be built by concatenation.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/queue_stream_adapter_if.sv
// queue_stream_adapter_if
// Bundles the upstream queue read port and the downstream valid/ready stream.
// Ports / signals:
//   q_read_en     read request to the upstream queue
//   q_data_out    queue read data
//   q_data_valid  queue read data qualifier
//   m_valid       stream data available
//   m_data        stream data
//   m_ready       downstream accepts
// Modports: master = the adapter, slave = the queue/stream environment.

interface queue_stream_adapter_if
    import queue_stream_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = QSA_DATA_WIDTH
);

    logic                  q_read_en;
    logic [DATA_WIDTH-1:0] q_data_out;
    logic                  q_data_valid;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output q_read_en,
        input  q_data_out,
        input  q_data_valid,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  q_read_en,
        output q_data_out,
        output q_data_valid,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/queue_stream_adapter_skid_fifo.sv
// skid_fifo
// Show-ahead FIFO holding queue words until the stream accepts them.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   push         write push_data at the tail (dropped when full with no pop)
//   push_data    tail write data
//   pop          remove the head entry
//   head_data    current head entry (don't-care when head_valid is low)
//   head_valid   FIFO not empty
//   count        current occupancy, 0..DEPTH

module skid_fifo
    import queue_stream_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = QSA_DATA_WIDTH,
    parameter int unsigned DEPTH      = QSA_SKID_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic     full;
    logic     empty;
    logic     do_push;
    logic     do_pop;
    fifo_op_e op;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is still legal when the head leaves the same
    // cycle: the slot being freed is exactly the one the write pointer names.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign op      = fifo_op_e'({do_push, do_pop});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; contents only matter once
    // the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_data  = mem[rd_ptr_q];
    assign head_valid = !empty;
    assign count      = count_q;

endmodule

// File: rtl/queue_stream_adapter.sv
// queue_stream_adapter
// Turns a fixed-latency queue read port into a valid/ready stream. Reads are
// issued on credit: a read is only requested when the skid FIFO is guaranteed
// to have room for its data, counting every read still in flight.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   enable     allows new queue reads (in-flight returns are always accepted)
//   bus        queue read port + output stream (master modport)
//   level      skid FIFO occupancy
//   overflow   sticky: queue data arrived while the FIFO was full

module queue_stream_adapter
    import queue_stream_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = QSA_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = QSA_READ_LATENCY,
    parameter int unsigned SKID_DEPTH   = QSA_SKID_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    queue_stream_adapter_if.master        bus,
    output logic [$clog2(SKID_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int unsigned LW = $clog2(SKID_DEPTH) + 1;

    logic [READ_LATENCY-1:0] issued_q, issued_d;
    logic                    overflow_q, overflow_d;
    logic [LW-1:0]           inflight;
    logic [LW:0]             credit_sum;
    logic                    read_en;
    logic                    push;
    logic                    pop;
    logic [LW-1:0]           fifo_count;

    // Each bit is one read issued within the last READ_LATENCY cycles. A read
    // into an empty queue never returns data, so its credit simply ages out.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + LW'(issued_q[i]);
        end
    end

    // Uses the registered level only: a pop this cycle is not credited, which
    // keeps q_read_en free of any path from m_ready or q_data_valid.
    assign credit_sum = (LW + 1)'(fifo_count) + (LW + 1)'(inflight);
    assign read_en    = enable && !rst && (credit_sum < (LW + 1)'(SKID_DEPTH));

    assign push = bus.q_data_valid;
    assign pop  = bus.m_valid && bus.m_ready;

    always_comb begin
        issued_d   = (issued_q << 1) | READ_LATENCY'(read_en);
        overflow_d = overflow_q;
        if (push && (fifo_count == LW'(SKID_DEPTH)) && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            issued_q   <= issued_d;
            overflow_q <= overflow_d;
        end
    end

    skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (bus.q_data_out),
        .pop        (pop),
        .head_data  (bus.m_data),
        .head_valid (bus.m_valid),
        .count      (fifo_count)
    );

    assign bus.q_read_en = read_en;
    assign level         = fifo_count;
    assign overflow      = overflow_q;

endmodule

// File: doc/queue_stream_adapter.md
QUEUE_STREAM_ADAPTER -- requirements
Module: queue_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of queue output word and stream data.
REQ-002 SHALL have parameter READ_LATENCY, default 4: cycles from q_read_en high to the matching q_data_valid.
REQ-003 SHALL have parameter SKID_DEPTH, default 8: skid FIFO entries; power of two, >= READ_LATENCY+1.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  permits issuing new queue reads when high.
REQ-007 q_read_en  output  1  read request to upstream multibuffer queue.
REQ-008 q_data_out  input  DATA_WIDTH  queue read data, qualified by q_data_valid.
REQ-009 q_data_valid  input  1  queue data valid, READ_LATENCY cycles after an accepted read.
REQ-010 m_valid  output  1  stream data available.
REQ-011 m_data  output  DATA_WIDTH  stream data, stable while m_valid && !m_ready.
REQ-012 m_ready  input  1  downstream accepts when high.
REQ-013 level  output  clog2(SKID_DEPTH)+1  current skid FIFO occupancy.
REQ-014 overflow  output  1  sticky error: q_data_valid arrived while FIFO full.

Function
REQ-015 SHALL keep a READ_LATENCY-bit shift register of issued q_read_en; inflight = popcount of it.
REQ-016 SHALL drive q_read_en = enable && (level_next_pop_excluded + inflight) < SKID_DEPTH, where level_next_pop_excluded is the registered level (pop in same cycle is not credited).
REQ-017 q_read_en SHALL be combinational from registered state and enable only; no path from q_data_valid or m_ready.
REQ-018 A read issued while the queue is empty returns no q_data_valid; its credit SHALL be released when it leaves the shift register, READ_LATENCY cycles later.
REQ-019 q_data_valid high SHALL push q_data_out into the FIFO tail that cycle; m_valid SHALL rise the next cycle if FIFO was empty (1-cycle pass latency).
REQ-020 FIFO SHALL be show-ahead: m_data = head entry, m_valid = (level != 0).
REQ-021 Pop SHALL occur on m_valid && m_ready; push and pop in same cycle SHALL leave level unchanged and both take effect.
REQ-022 Read/write pointers SHALL be clog2(SKID_DEPTH) bits and wrap modulo SKID_DEPTH.
REQ-023 Push while level == SKID_DEPTH and no pop SHALL drop data, leave state unchanged, and set overflow until reset.
REQ-024 With enable and m_ready held high and queue non-empty, SHALL sustain one word per cycle after initial READ_LATENCY+1 cycles.
REQ-025 enable low SHALL stop new reads only; in-flight returns SHALL still be accepted.

Reset
REQ-026 rst SHALL clear pointers, level, shift register and overflow; m_valid=0, q_read_en=0, level=0, overflow=0 while rst high.
REQ-027 FIFO storage SHALL not be reset; m_data is don't-care while m_valid=0.
REQ-028 Reset mid-operation SHALL discard FIFO contents and in-flight credits; upstream queue is reset by the same rst.

Structure
REQ-029 Shared package SHALL hold default DATA_WIDTH and READ_LATENCY constants common with the queue.
REQ-030 Skid storage SHALL be one sub-module, skid_fifo (show-ahead, count output); credit logic stays in the top.

Verification
REQ-031 enable=1, m_ready=1, queue preloaded 16 words 0..15 -> m_data 0..15 in order, gap-free after first word, level <= 1.
REQ-032 m_ready=0, enable=1, queue 20 words -> q_read_en drops after 8 issued, level settles at 8, overflow=0; m_ready=1 then delivers 0..19 in order.
REQ-033 Queue empty, enable=1 for 10 cycles, q_data_valid=0 -> q_read_en pulses continue, inflight never exceeds 4, level=0, m_valid=0.
REQ-034 Random m_ready (50%) over 1000 words -> in-order, no loss, no duplicate, overflow=0.
REQ-035 Force q_data_valid with level=8, m_ready=0 -> overflow=1 next cycle, level stays 8, head data unchanged.
REQ-036 Assert rst with level=5 and 3 reads in flight -> level=0, m_valid=0, overflow=0 next edge; q_read_en restarts after rst release.
